silife_grid_sync_initiator: RTL

SILIFE_GRID_SYNC_INITIATOR -- requirements
Module: silife_grid_sync_initiator

---
 rtl/silife_grid_sync_initiator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/silife_grid_sync_initiator.sv
// Initiator side of the SiLife grid edge exchange: serialises a local edge row
// plus edge bit over a generated sync clock and captures the responder's row.
module silife_grid_sync_initiator #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_edge,
    input  logic [WIDTH-1:0] i_cells,
    output logic             o_edge,
    output logic [WIDTH-1:0] o_cells,
    output logic             o_sync_clk_syn,
    output logic             o_sync_active_syn,
    output logic             o_sync_out_syn,
    input  logic             i_sync_in_syn
);

    localparam int JW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [JW-1:0]    j_r;
    logic [WIDTH:0]   tx_r;
    logic [WIDTH-1:0] rx_r;
    logic             sync_q1_r;
    logic             sync_q2_r;
    logic             busy_r;
    logic             done_r;
    logic             edge_r;
    logic [WIDTH-1:0] cells_r;
    logic             sclk_r;
    logic             active_r;
    logic             sout_r;
    logic             phase_last_s;

    // Frame bit j of the TX shadow; index WIDTH is the edge bit.
    function automatic logic tx_bit(input logic [WIDTH:0] vec, input logic [JW-1:0] idx);
        logic b;
        b = 1'b0;
        for (int k = 0; k <= WIDTH; k++) begin
            if (idx == JW'(k)) begin
                b = vec[k];
            end
        end
        return b;
    endfunction

    assign phase_last_s      = (cnt_r == CW'(CLK_DIV - 1));
    assign o_busy            = busy_r;
    assign o_done            = done_r;
    assign o_edge            = edge_r;
    assign o_cells           = cells_r;
    assign o_sync_clk_syn    = sclk_r;
    assign o_sync_active_syn = active_r;
    assign o_sync_out_syn    = sout_r;

    // Two-flop synchronizer for the responder's serial data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1_r <= 1'b0;
            sync_q2_r <= 1'b0;
        end else begin
            sync_q1_r <= i_sync_in_syn;
            sync_q2_r <= sync_q1_r;
        end
    end

    // Exchange FSM with registered sync-line and result outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            j_r      <= '0;
            tx_r     <= '0;
            rx_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            edge_r   <= 1'b0;
            cells_r  <= '0;
            sclk_r   <= 1'b0;
            active_r <= 1'b0;
            sout_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        tx_r     <= {i_edge, i_cells};
                        j_r      <= '0;
                        cnt_r    <= '0;
                        state_r  <= ST_LOW;
                        busy_r   <= 1'b1;
                        active_r <= 1'b1;
                        sclk_r   <= 1'b0;
                        sout_r   <= i_cells[0];
                    end else begin
                        cnt_r <= '0;
                    end
                end
                ST_LOW: begin
                    if (phase_last_s) begin
                        cnt_r   <= '0;
                        state_r <= ST_HIGH;
                        sclk_r  <= 1'b1;
                        // Responder bit j-1 has settled since falling edge j.
                        for (int k = 0; k < WIDTH; k++) begin
                            if (j_r == JW'(k + 1)) begin
                                rx_r[k] <= sync_q2_r;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (phase_last_s) begin
                        cnt_r  <= '0;
                        sclk_r <= 1'b0;
                        if (j_r == JW'(WIDTH)) begin
                            state_r <= ST_TAIL;
                            sout_r  <= 1'b0;
                        end else begin
                            state_r <= ST_LOW;
                            j_r     <= j_r + JW'(1);
                            sout_r  <= tx_bit(tx_r, j_r + JW'(1));
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_TAIL: begin
                    if (phase_last_s) begin
                        cnt_r    <= '0;
                        j_r      <= '0;
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        active_r <= 1'b0;
                        done_r   <= 1'b1;
                        cells_r  <= rx_r;
                        edge_r   <= sync_q2_r;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cnt_r    <= '0;
                    j_r      <= '0;
                    busy_r   <= 1'b0;
                    active_r <= 1'b0;
                    sclk_r   <= 1'b0;
                    sout_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule
